// File: rtl/pc_unit.sv
// pc_unit: program counter with branch, jump, exception and eret selection.
// Optional return-address stack is built only when PC_RAS_EN is defined.
module pc_unit #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_ADDR = 'h0000_3000,
   parameter logic [WIDTH-1:0] EXC_ADDR   = 'h0000_4180,
   parameter int               STEP       = 4,
   parameter int               RAS_DEPTH  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             br_en,
   input  logic [WIDTH-1:0] br_off,
   input  logic             jmp_en,
   input  logic [WIDTH-1:0] jmp_tgt,
   input  logic             exc,
   input  logic             eret,
   input  logic             call_en,
   input  logic             ret_en,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus,
   output logic [WIDTH-1:0] epc,
   output logic             misalign,
   output logic             ras_err
);

   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_epc;
   logic             r_misalign;
   logic [WIDTH-1:0] w_pc_plus;
   logic [WIDTH-1:0] w_next_pc;
   logic [WIDTH-1:0] w_next_epc;
   logic             w_normal;
   logic             w_take_ret;
   logic [WIDTH-1:0] w_ret_addr;

   assign w_pc_plus = r_pc + WIDTH'(STEP);
   // Stack activity is only allowed on cycles that are not exc, eret or stall.
   assign w_normal  = !exc && !eret && !stall;

`ifdef PC_RAS_EN
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_ras [RAS_DEPTH];
   logic [PTR_W-1:0] r_top;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ras_err;
   logic [PTR_W-1:0] w_top_pop;
   logic [PTR_W-1:0] w_top_next;
   logic [CNT_W-1:0] w_cnt_pop;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_pop;
   logic             w_push;
   logic             w_ras_err;

   assign w_pop      = w_normal && ret_en;
   assign w_push     = w_normal && call_en && jmp_en;
   assign w_take_ret = w_pop;
   assign w_ret_addr = (r_cnt == '0) ? w_pc_plus : r_ras[r_top];

   // Pop is applied first, then push; a combined call+ret rewrites the top slot.
   always_comb begin
      w_top_pop  = r_top;
      w_cnt_pop  = r_cnt;
      w_ras_err  = 1'b0;
      if (w_pop) begin
         if (r_cnt == '0) begin
            w_ras_err = 1'b1;
         end else begin
            w_top_pop = r_top - PTR_W'(1);
            w_cnt_pop = r_cnt - CNT_W'(1);
         end
      end
      w_top_next = w_top_pop;
      w_cnt_next = w_cnt_pop;
      if (w_push) begin
         w_top_next = w_top_pop + PTR_W'(1);
         if (w_cnt_pop == CNT_W'(RAS_DEPTH)) begin
            w_ras_err = 1'b1;
         end else begin
            w_cnt_next = w_cnt_pop + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_top     <= '0;
         r_cnt     <= '0;
         r_ras_err <= 1'b0;
      end else begin
         r_top     <= w_top_next;
         r_cnt     <= w_cnt_next;
         r_ras_err <= w_ras_err;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_ras[w_top_next] <= w_pc_plus;
      end
   end

   assign ras_err = r_ras_err;
`else
   logic w_unused_ras;

   assign w_take_ret   = 1'b0;
   assign w_ret_addr   = w_pc_plus;
   assign ras_err      = 1'b0;
   assign w_unused_ras = call_en ^ ret_en;
`endif

   always_comb begin
      w_next_pc  = r_pc;
      w_next_epc = r_epc;
      if (exc) begin
         w_next_pc  = EXC_ADDR;
         w_next_epc = r_pc;
      end else if (eret) begin
         w_next_pc = r_epc;
      end else if (stall) begin
         w_next_pc = r_pc;
      end else if (w_take_ret) begin
         w_next_pc = w_ret_addr;
      end else if (jmp_en) begin
         w_next_pc = jmp_tgt;
      end else if (br_en) begin
         w_next_pc = w_pc_plus + br_off;
      end else begin
         w_next_pc = w_pc_plus;
      end
   end

   // misalign is computed from the next PC so it lines up with the loaded target.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc       <= RESET_ADDR;
         r_epc      <= '0;
         r_misalign <= 1'b0;
      end else begin
         r_pc       <= w_next_pc;
         r_epc      <= w_next_epc;
         r_misalign <= |w_next_pc[1:0];
      end
   end

   assign pc       = r_pc;
   assign pc_plus  = w_pc_plus;
   assign epc      = r_epc;
   assign misalign = r_misalign;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic
// checked against a behavioural next-PC model with a queue-based return stack.
module tb_pc_unit;

   localparam int          W         = 32;
   localparam int          DEPTH     = 4;
   localparam logic [31:0] RESET_PC  = 32'h0000_3000;
   localparam logic [31:0] EXC_PC    = 32'h0000_4180;

   logic         clk;
   logic         rst;
   logic         stall;
   logic         br_en;
   logic [W-1:0] br_off;
   logic         jmp_en;
   logic [W-1:0] jmp_tgt;
   logic         exc;
   logic         eret;
   logic         call_en;
   logic         ret_en;
   logic [W-1:0] pc;
   logic [W-1:0] pc_plus;
   logic [W-1:0] epc;
   logic         misalign;
   logic         ras_err;

   int checks;
   int errors;

   logic [W-1:0] m_pc;
   logic [W-1:0] m_epc;
   logic         m_err;
   logic [W-1:0] m_ras[$];
   logic [W-1:0] exp_q[$];

   pc_unit dut (
      .clk      (clk),
      .rst      (rst),
      .stall    (stall),
      .br_en    (br_en),
      .br_off   (br_off),
      .jmp_en   (jmp_en),
      .jmp_tgt  (jmp_tgt),
      .exc      (exc),
      .eret     (eret),
      .call_en  (call_en),
      .ret_en   (ret_en),
      .pc       (pc),
      .pc_plus  (pc_plus),
      .epc      (epc),
      .misalign (misalign),
      .ras_err  (ras_err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      stall   = 1'b0;
      br_en   = 1'b0;
      br_off  = '0;
      jmp_en  = 1'b0;
      jmp_tgt = '0;
      exc     = 1'b0;
      eret    = 1'b0;
      call_en = 1'b0;
      ret_en  = 1'b0;
   endtask

   task automatic model_reset();
      m_pc  = RESET_PC;
      m_epc = '0;
      m_err = 1'b0;
      m_ras.delete();
   endtask

   // Reference next-PC rule: priority exc > eret > stall > ret > jmp > br > +4.
   task automatic model_edge();
      logic [W-1:0] plus;
      logic [W-1:0] nxt;
      logic         err;
      plus = m_pc + 32'd4;
      err  = 1'b0;
      if (exc) begin
         m_epc = m_pc;
         nxt   = EXC_PC;
      end else if (eret) begin
         nxt = m_epc;
      end else if (stall) begin
         nxt = m_pc;
      end else begin
         if (jmp_en)     nxt = jmp_tgt;
         else if (br_en) nxt = plus + br_off;
         else            nxt = plus;
`ifdef PC_RAS_EN
         if (ret_en) begin
            if (m_ras.size() == 0) begin
               nxt = plus;
               err = 1'b1;
            end else begin
               nxt = m_ras.pop_back();
            end
         end
         if (call_en && jmp_en) begin
            m_ras.push_back(plus);
            if (m_ras.size() > DEPTH) begin
               void'(m_ras.pop_front());
               err = 1'b1;
            end
         end
`endif
      end
      m_pc  = nxt;
      m_err = err;
   endtask

   // driver: one clock edge, model advanced in step, outputs sampled 1ns later
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic load_pc(input logic [W-1:0] tgt);
      clear_inputs();
      jmp_en  = 1'b1;
      jmp_tgt = tgt;
      tick();
      clear_inputs();
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      #2;
      checks++;
      if (pc !== RESET_PC) begin
         errors++;
         $display("FAIL reset_pc got %h exp %h", pc, RESET_PC);
      end
      checks++;
      if (epc !== 32'h0 || misalign !== 1'b0 || ras_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got epc=%h mis=%b err=%b exp 0/0/0", epc, misalign, ras_err);
      end
      #1;
      rst = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if (pc !== RESET_PC + 32'(4 * i)) begin
            errors++;
            $display("FAIL reset_resume%0d got %h exp %h", i, pc, RESET_PC + 32'(4 * i));
         end
      end
   endtask

   task automatic test_branch_jump();
      load_pc(32'h0000_3010);
      br_en  = 1'b1;
      br_off = 32'hFFFF_FFF0;
      tick();
      checks++;
      if (pc !== 32'h0000_3004) begin
         errors++;
         $display("FAIL branch_back got %h exp %h", pc, 32'h0000_3004);
      end
      load_pc(32'h0000_3010);
      br_en   = 1'b1;
      br_off  = 32'hFFFF_FFF0;
      jmp_en  = 1'b1;
      jmp_tgt = 32'h0000_3100;
      tick();
      checks++;
      if (pc !== 32'h0000_3100) begin
         errors++;
         $display("FAIL jump_over_branch got %h exp %h", pc, 32'h0000_3100);
      end
      clear_inputs();
      tick();
      checks++;
      if (pc !== 32'h0000_3104 || pc_plus !== 32'h0000_3108) begin
         errors++;
         $display("FAIL seq_after_jump got %h/%h exp 3104/3108", pc, pc_plus);
      end
   endtask

   task automatic test_exception();
      load_pc(32'h0000_3020);
      stall = 1'b1;
      exc   = 1'b1;
      tick();
      checks++;
      if (pc !== EXC_PC || epc !== 32'h0000_3020) begin
         errors++;
         $display("FAIL exc_over_stall got pc=%h epc=%h exp %h/%h", pc, epc, EXC_PC, 32'h0000_3020);
      end
      clear_inputs();
      eret = 1'b1;
      tick();
      checks++;
      if (pc !== 32'h0000_3020 || epc !== 32'h0000_3020) begin
         errors++;
         $display("FAIL eret got pc=%h epc=%h exp 3020/3020", pc, epc);
      end
      clear_inputs();
      stall   = 1'b1;
      jmp_en  = 1'b1;
      jmp_tgt = 32'h0000_5555;
      call_en = 1'b1;
      ret_en  = 1'b1;
      tick();
      checks++;
      if (pc !== 32'h0000_3020 || ras_err !== 1'b0) begin
         errors++;
         $display("FAIL stall_hold got pc=%h err=%b exp 3020/0", pc, ras_err);
      end
      clear_inputs();
   endtask

   task automatic test_misalign();
      load_pc(32'h0000_3102);
      checks++;
      if (pc !== 32'h0000_3102 || misalign !== 1'b1) begin
         errors++;
         $display("FAIL misalign_load got pc=%h mis=%b exp 3102/1", pc, misalign);
      end
      tick();
      checks++;
      if (pc !== 32'h0000_3106 || misalign !== 1'b1) begin
         errors++;
         $display("FAIL misalign_inc got pc=%h mis=%b exp 3106/1", pc, misalign);
      end
      load_pc(32'h0000_3108);
      checks++;
      if (misalign !== 1'b0) begin
         errors++;
         $display("FAIL misalign_clear got %b exp 0", misalign);
      end
   endtask

   task automatic test_wrap();
      load_pc(32'hFFFF_FFFC);
      checks++;
      if (pc_plus !== 32'h0000_0000) begin
         errors++;
         $display("FAIL wrap_plus got %h exp 00000000", pc_plus);
      end
      tick();
      checks++;
      if (pc !== 32'h0000_0000 || misalign !== 1'b0 || ras_err !== 1'b0) begin
         errors++;
         $display("FAIL wrap_pc got pc=%h mis=%b err=%b exp 0/0/0", pc, misalign, ras_err);
      end
   endtask

`ifdef PC_RAS_EN
   task automatic test_ras();
      logic [W-1:0] prev;
      logic [W-1:0] want;
      exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         clear_inputs();
         jmp_en  = 1'b1;
         call_en = 1'b1;
         jmp_tgt = 32'h0000_5000 + 32'(i * 256);
         exp_q.push_back(m_pc + 32'd4);
         tick();
         checks++;
         if (pc !== jmp_tgt || ras_err !== (i == 4)) begin
            errors++;
            $display("FAIL ras_call%0d got pc=%h err=%b exp %h/%b", i, pc, ras_err, jmp_tgt, i == 4);
         end
      end
      void'(exp_q.pop_front());
      for (int i = 0; i < 5; i++) begin
         clear_inputs();
         ret_en = 1'b1;
         prev   = pc;
         tick();
         want = (exp_q.size() > 0) ? exp_q.pop_back() : prev + 32'd4;
         checks++;
         if (pc !== want || ras_err !== (i == 4)) begin
            errors++;
            $display("FAIL ras_ret%0d got pc=%h err=%b exp %h/%b", i, pc, ras_err, want, i == 4);
         end
      end
      clear_inputs();
      tick();
      checks++;
      if (ras_err !== 1'b0) begin
         errors++;
         $display("FAIL ras_err_pulse got %b exp 0", ras_err);
      end
   endtask
`else
   task automatic test_ras();
      load_pc(32'h0000_3200);
      jmp_en  = 1'b1;
      call_en = 1'b1;
      ret_en  = 1'b1;
      jmp_tgt = 32'h0000_3300;
      tick();
      checks++;
      if (pc !== 32'h0000_3300 || ras_err !== 1'b0) begin
         errors++;
         $display("FAIL no_ras_call got pc=%h err=%b exp 3300/0", pc, ras_err);
      end
      clear_inputs();
      ret_en = 1'b1;
      tick();
      checks++;
      if (pc !== 32'h0000_3304 || ras_err !== 1'b0) begin
         errors++;
         $display("FAIL no_ras_ret got pc=%h err=%b exp 3304/0", pc, ras_err);
      end
      clear_inputs();
   endtask
`endif

   task automatic test_random();
      for (int n = 0; n < 500; n++) begin
         exc     = ($urandom_range(0, 19) == 0);
         eret    = ($urandom_range(0, 15) == 0);
         stall   = ($urandom_range(0, 7) == 0);
         jmp_en  = ($urandom_range(0, 3) == 0);
         br_en   = ($urandom_range(0, 3) == 0);
         call_en = ($urandom_range(0, 1) == 1);
         ret_en  = ($urandom_range(0, 4) == 0);
         jmp_tgt = $urandom();
         if ($urandom_range(0, 3) != 0) jmp_tgt[1:0] = 2'b00;
         br_off  = $urandom();
         tick();
         checks++;
         if (pc !== m_pc || pc_plus !== m_pc + 32'd4 || epc !== m_epc) begin
            errors++;
            $display("FAIL rand_pc cycle %0d got pc=%h plus=%h epc=%h exp %h/%h/%h",
                     n, pc, pc_plus, epc, m_pc, m_pc + 32'd4, m_epc);
         end
         checks++;
         if (misalign !== (m_pc[1:0] != 2'b00) || ras_err !== m_err) begin
            errors++;
            $display("FAIL rand_flags cycle %0d got mis=%b err=%b exp %b/%b",
                     n, misalign, ras_err, m_pc[1:0] != 2'b00, m_err);
         end
      end
      clear_inputs();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clear_inputs();
      rst = 1'b0;
      model_reset();
      #12;
      rst = 1'b1;
      tick();
      test_reset();
      test_branch_jump();
      test_exception();
      test_misalign();
      test_wrap();
      test_reset();
      test_ras();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
